// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback stage.
//   DEF_DATA_W / DEF_REG_AW / DEF_DEPTH : default result width, register index
//                                         width and FIFO depth
//   wb_entry_t                          : one queued writeback {data, rd, zero}
//   is_trap_ov()                        : true when an op must raise an overflow
//                                         exception instead of writing back
package alu_wb_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;
  localparam int unsigned DEF_DEPTH  = 2;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_REG_AW-1:0] rd;
    logic                  zero;
  } wb_entry_t;

  function automatic logic is_trap_ov(input logic trap, input logic ov);
    return trap & ov;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO used as the writeback queue.
// Optional feature macro: ALU_WB_FWD_EN (exposes age-ordered storage for the
// forwarding search).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the queue)
//   push_i        : write din_i at the tail (ignored when full)
//   pop_i         : advance the head (ignored when empty)
//   din_i         : entry to enqueue
//   head_o        : oldest entry, all-zero when empty
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
//   ord_o         : (ALU_WB_FWD_EN) storage ordered oldest (index 0) to youngest
//   valid_o       : (ALU_WB_FWD_EN) ord_o[i] holds a live entry
module wb_fifo
  import alu_wb_pkg::*;
#(
  parameter type         entry_t = wb_entry_t,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  entry_t           din_i,
  output entry_t           head_o,
  output logic             full_o,
  output logic             empty_o
`ifdef ALU_WB_FWD_EN
  ,
  output entry_t           ord_o [DEPTH],
  output logic [DEPTH-1:0] valid_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Head is muxed from storage only, so it never depends on this cycle's inputs.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

`ifdef ALU_WB_FWD_EN
  always_comb begin
    valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ord_o[i]   = mem_q[rd_ptr_q + AW'(i)];
      valid_o[i] = ((AW+1)'(i) < count_q);
    end
  end
`endif

endmodule

// File: rtl/alu_wb_stage.sv
// Writeback stage downstream of the ALU: queues results for the register-file
// write port and turns trapping add/sub overflow into an exception handshake.
// Optional feature macro: ALU_WB_FWD_EN (adds the fwd_* forwarding query).
// Ports:
//   m_clock, p_reset           : clock, asynchronous active-low reset
//   in_valid/in_ready          : ALU result handshake
//   in_out, in_overflow,
//   in_zero, in_rd, in_trap    : ALU result, flags, destination, trap-on-overflow
//   wb_valid/wb_ready          : register-file write handshake for the head entry
//   wb_data, wb_rd, wb_zero    : head entry, all zero when the queue is empty
//   exc_valid, exc_rd, exc_ack : pending overflow exception and its acknowledge
//   fwd_rs, fwd_hit, fwd_data  : (ALU_WB_FWD_EN) youngest queued value for fwd_rs
module alu_wb_stage
  import alu_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_out,
  input  logic              in_overflow,
  input  logic              in_zero,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_trap,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_zero,
  output logic              exc_valid,
  output logic [REG_AW-1:0] exc_rd,
  input  logic              exc_ack
`ifdef ALU_WB_FWD_EN
  ,
  input  logic [REG_AW-1:0] fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rd;
    logic              zero;
  } entry_t;

  entry_t            fifo_din, fifo_head;
  logic              fifo_full, fifo_empty;
  logic              run_q;
  logic              exc_q, exc_d;
  logic [REG_AW-1:0] exc_rd_q, exc_rd_d;
  logic              accept, trap_ov, push, pop;

`ifdef ALU_WB_FWD_EN
  entry_t            fifo_ord [DEPTH];
  logic [DEPTH-1:0]  fifo_vld;
`endif

  // run_q keeps in_ready low while reset is held and for the release edge,
  // since the queue and exception flag alone would already look "ready".
  assign in_ready = run_q & ~fifo_full & ~exc_q;
  assign accept   = in_valid & in_ready;
  assign trap_ov  = is_trap_ov(in_trap, in_overflow);
  // Writes to r0 are accepted and silently dropped.
  assign push     = accept & ~trap_ov & (in_rd != '0);
  assign pop      = ~fifo_empty & wb_ready;

  assign fifo_din = '{data: in_out, rd: in_rd, zero: in_zero};

  wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk_i   (m_clock),
    .rst_ni  (p_reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
`ifdef ALU_WB_FWD_EN
    ,
    .ord_o   (fifo_ord),
    .valid_o (fifo_vld)
`endif
  );

  assign wb_valid = ~fifo_empty;
  assign wb_data  = fifo_head.data;
  assign wb_rd    = fifo_head.rd;
  assign wb_zero  = fifo_head.zero;

  // A new exception can only be accepted while none is pending, so set and
  // acknowledge never coincide.
  always_comb begin
    exc_d    = exc_q;
    exc_rd_d = exc_rd_q;
    if (exc_q && exc_ack) begin
      exc_d    = 1'b0;
      exc_rd_d = '0;
    end else if (accept && trap_ov) begin
      exc_d    = 1'b1;
      exc_rd_d = in_rd;
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      run_q    <= 1'b0;
      exc_q    <= 1'b0;
      exc_rd_q <= '0;
    end else begin
      run_q    <= 1'b1;
      exc_q    <= exc_d;
      exc_rd_q <= exc_rd_d;
    end
  end

  assign exc_valid = exc_q;
  assign exc_rd    = exc_rd_q;

`ifdef ALU_WB_FWD_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_ord[i].rd == fwd_rs) && (fwd_rs != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_ord[i].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed vector table, reset corner
// sequences, and randomized traffic against a queue-based reference model.
// Optional feature macro: ALU_WB_FWD_EN (enables forwarding checks).
module tb_alu_wb_stage;

  localparam int unsigned DEPTH = 2;

  logic        m_clock = 1'b0;
  logic        p_reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_out = '0;
  logic        in_overflow = 1'b0;
  logic        in_zero = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_trap = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_zero;
  logic        exc_valid;
  logic [4:0]  exc_rd;
  logic        exc_ack = 1'b0;
`ifdef ALU_WB_FWD_EN
  logic [4:0]  fwd_rs = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 m_clock = ~m_clock;

  alu_wb_stage #(.DATA_W(32), .REG_AW(5), .DEPTH(DEPTH)) dut (
    .m_clock     (m_clock),
    .p_reset     (p_reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_out      (in_out),
    .in_overflow (in_overflow),
    .in_zero     (in_zero),
    .in_rd       (in_rd),
    .in_trap     (in_trap),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_zero     (wb_zero),
    .exc_valid   (exc_valid),
    .exc_rd      (exc_rd),
    .exc_ack     (exc_ack)
`ifdef ALU_WB_FWD_EN
    ,
    .fwd_rs      (fwd_rs),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data)
`endif
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        z, trap, ov, wbr, ack;
    logic        e_ir, e_wv;
    logic [4:0]  e_wrd;
    logic [31:0] e_wd;
    logic        e_wz, e_ev;
    logic [4:0]  e_erd;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        zero;
  } ent_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic v, input logic [4:0] rd, input logic [31:0] d,
                               input logic z, input logic trap, input logic ov,
                               input logic wbr, input logic ack,
                               input logic e_ir, input logic e_wv, input logic [4:0] e_wrd,
                               input logic [31:0] e_wd, input logic e_wz, input logic e_ev,
                               input logic [4:0] e_erd);
    vec_t r;
    r.v = v; r.rd = rd; r.d = d; r.z = z; r.trap = trap; r.ov = ov; r.wbr = wbr; r.ack = ack;
    r.e_ir = e_ir; r.e_wv = e_wv; r.e_wrd = e_wrd; r.e_wd = e_wd; r.e_wz = e_wz;
    r.e_ev = e_ev; r.e_erd = e_erd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic z, input logic trap, input logic ov,
                       input logic wbr, input logic ack);
    in_valid = v; in_rd = rd; in_out = d; in_zero = z; in_trap = trap;
    in_overflow = ov; wb_ready = wbr; exc_ack = ack;
  endtask

  task automatic chk_outs(input string tag, input logic ir, input logic wv, input logic [4:0] wrd,
                          input logic [31:0] wd, input logic wz, input logic ev,
                          input logic [4:0] erd);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, ".wb_valid"},  32'(wb_valid),  32'(wv));
    chk({tag, ".wb_rd"},     32'(wb_rd),     32'(wrd));
    chk({tag, ".wb_data"},   wb_data,        wd);
    chk({tag, ".wb_zero"},   32'(wb_zero),   32'(wz));
    chk({tag, ".exc_valid"}, 32'(exc_valid), 32'(ev));
    chk({tag, ".exc_rd"},    32'(exc_rd),    32'(erd));
  endtask

  task automatic next_cycle();
    @(posedge m_clock);
    #1;
  endtask

  // Reference model state
  ent_t        mq[$];
  logic        m_exc;
  logic [4:0]  m_erd;

  initial begin
    // ---------------- reset held for 3 cycles ----------------
    repeat (3) begin
      @(negedge m_clock);
      chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge m_clock);
    p_reset = 1'b1;
    #1 chk("release.in_ready_same_cycle", 32'(in_ready), 32'd0);
    next_cycle();
    chk("release.in_ready_next", 32'(in_ready), 32'd1);

    // ---------------- directed vector table ----------------
    //            v  rd  data          z tr ov wbr ack  ir wv wrd wdata         wz ev erd
    tbl.push_back(row(1, 3, 32'h5,          0, 0, 0, 1, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  1, 1, 3,  32'h5,         0, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(1, 1, 32'h11,         0, 0, 0, 0, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(1, 2, 32'h22,         1, 0, 0, 0, 0,  1, 1, 1,  32'h11,        0, 0, 0));
    tbl.push_back(row(1, 9, 32'h99,         0, 0, 0, 0, 0,  0, 1, 1,  32'h11,        0, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  0, 1, 1,  32'h11,        0, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  1, 1, 2,  32'h22,        1, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(1, 7, 32'h123,        0, 1, 1, 1, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  0, 0, 0,  32'h0,         0, 1, 7));
    tbl.push_back(row(1, 6, 32'h66,         0, 0, 0, 1, 0,  0, 0, 0,  32'h0,         0, 1, 7));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 1,  0, 0, 0,  32'h0,         0, 1, 7));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 1,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(1, 4, 32'h8000_0000,  0, 0, 1, 1, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(1, 0, 32'hFFFF_FFFF,  1, 0, 0, 1, 0,  1, 1, 4,  32'h8000_0000, 0, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(1, 8, 32'h42,         0, 1, 0, 1, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  1, 1, 8,  32'h42,        0, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(1, 10, 32'hA,         0, 0, 0, 0, 0,  1, 0, 0,  32'h0,         0, 0, 0));
    tbl.push_back(row(1, 11, 32'hB,         1, 0, 0, 1, 0,  1, 1, 10, 32'hA,         0, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  1, 1, 11, 32'hB,         1, 0, 0));
    tbl.push_back(row(0, 0, 32'h0,          0, 0, 0, 1, 0,  1, 0, 0,  32'h0,         0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].d, tbl[i].z, tbl[i].trap, tbl[i].ov, tbl[i].wbr, tbl[i].ack);
      @(negedge m_clock);
      chk_outs($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_wv, tbl[i].e_wrd, tbl[i].e_wd,
               tbl[i].e_wz, tbl[i].e_ev, tbl[i].e_erd);
      next_cycle();
    end

    // ---------------- mid-operation reset, queue full ----------------
    drive(1, 5, 32'hA, 0, 0, 0, 0, 0);
    next_cycle();
    drive(1, 5, 32'hB, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge m_clock);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.wb_data", wb_data, 32'hA);
`ifdef ALU_WB_FWD_EN
    fwd_rs = 5;
    #1 chk("fwd.hit_rd5", 32'(fwd_hit), 32'd1);
    chk("fwd.data_rd5", fwd_data, 32'hB);
    fwd_rs = 6;
    #1 chk("fwd.hit_rd6", 32'(fwd_hit), 32'd0);
    fwd_rs = 0;
    #1 chk("fwd.hit_rd0", 32'(fwd_hit), 32'd0);
`endif
    p_reset = 1'b0;
    #1 chk_outs("rst_full", 0, 0, 0, 0, 0, 0, 0);
    @(negedge m_clock);
    p_reset = 1'b1;
    next_cycle();

    // ---------------- mid-operation reset, entry queued + exception ----------------
    drive(1, 1, 32'h1, 0, 0, 0, 0, 0);
    next_cycle();
    drive(1, 7, 32'h7, 0, 1, 1, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge m_clock);
    chk_outs("exc_queued", 0, 1, 1, 32'h1, 0, 1, 7);
    p_reset = 1'b0;
    #1 chk_outs("rst_exc", 0, 0, 0, 0, 0, 0, 0);
`ifdef ALU_WB_FWD_EN
    fwd_rs = 1;
    #1 chk("fwd.after_reset", 32'(fwd_hit), 32'd0);
`endif
    @(negedge m_clock);
    p_reset = 1'b1;
    next_cycle();

    // ---------------- randomized traffic vs. reference model ----------------
    mq.delete();
    m_exc = 1'b0;
    m_erd = '0;
    for (int n = 0; n < 600; n++) begin
      logic v, z, tr, ov, wbr, ack, e_ir, e_wv, acc;
      logic [4:0] rd;
      logic [31:0] d;
      ent_t h;
      v   = ($urandom_range(0, 3) != 0);
      rd  = 5'($urandom_range(0, 7));
      d   = $urandom;
      z   = (d[3:0] == 4'h0);
      tr  = ($urandom_range(0, 3) == 0);
      ov  = ($urandom_range(0, 3) == 0);
      wbr = ($urandom_range(0, 1) == 0);
      ack = ($urandom_range(0, 2) == 0);
      drive(v, rd, d, z, tr, ov, wbr, ack);
`ifdef ALU_WB_FWD_EN
      fwd_rs = 5'($urandom_range(0, 7));
`endif
      e_ir = (mq.size() < DEPTH) && !m_exc;
      e_wv = (mq.size() > 0);
      h = '{data: 32'h0, rd: 5'h0, zero: 1'b0};
      if (e_wv) h = mq[0];
      @(negedge m_clock);
      chk_outs($sformatf("rnd%0d", n), e_ir, e_wv, h.rd, h.data, h.zero, m_exc, m_exc ? m_erd : 5'd0);
`ifdef ALU_WB_FWD_EN
      begin
        logic eh;
        logic [31:0] ed;
        eh = 1'b0;
        ed = '0;
        if (fwd_rs != 0)
          for (int k = mq.size() - 1; k >= 0; k--)
            if (mq[k].rd == fwd_rs) begin
              eh = 1'b1;
              ed = mq[k].data;
              break;
            end
        chk($sformatf("rnd%0d.fwd_hit", n), 32'(fwd_hit), 32'(eh));
        chk($sformatf("rnd%0d.fwd_data", n), fwd_data, ed);
      end
`endif
      // Advance model by one clock
      acc = v && e_ir;
      if (e_wv && wbr) void'(mq.pop_front());
      if (m_exc && ack) begin
        m_exc = 1'b0;
        m_erd = '0;
      end
      if (acc) begin
        if (tr && ov) begin
          m_exc = 1'b1;
          m_erd = rd;
        end else if (rd != 0) begin
          mq.push_back('{data: d, rd: rd, zero: z});
        end
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
